spr_arbiter: RTL and testbench
==============================

SPR_ARBITER -- requirements
Module: spr_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning RAM address width (16 words).
REQ-002 The block SHALL have parameter DW, default 8, meaning RAM data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports a_req, b_req, input, 1 each, access request from requester A or B.
REQ-006 The block SHALL have ports a_we, b_we, input, 1 each: 1 = write, 0 = read.
REQ-007 The block SHALL have ports a_addr, b_addr, input, AW each, word address.
REQ-008 The block SHALL have ports a_wdata, b_wdata, input, DW each, write data.
REQ-009 The block SHALL have ports a_gnt, b_gnt, output, 1 each, one-cycle grant pulse.
REQ-010 The block SHALL have ports a_done, b_done, output, 1 each, one-cycle completion pulse.
REQ-011 The block SHALL have ports a_rdata, b_rdata, output, DW each, read data, valid while and after done.
REQ-012 The block SHALL have ports ram_wr and ram_en, output, 1 each, RAM write strobe and read enable.
REQ-013 The block SHALL have port ram_add, output, AW, RAM address.
REQ-014 The block SHALL have port ram_d, inout, DW, shared RAM data bus.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and DONE, and SHALL return to IDLE after DONE unconditionally.
REQ-016 In IDLE with any req high at a clock edge, the FSM SHALL pick a winner, latch its we/addr/wdata, move to ACCESS and assert that requester's gnt for the ACCESS cycle only.
REQ-017 Requesters SHALL hold req and command stable until gnt; the block SHALL ignore command inputs after the latch.
REQ-018 In ACCESS, ram_add SHALL equal the latched address; for a write, ram_wr=1, ram_en=0 and ram_d is driven with the latched wdata; for a read, ram_wr=0, ram_en=1 and ram_d is hi-Z.
REQ-019 Outside ACCESS-write, ram_d SHALL be hi-Z; ram_wr and ram_en SHALL never be 1 in the same cycle.
REQ-020 On the edge leaving ACCESS after a read, the winner's rdata SHALL register ram_d; the other requester's rdata SHALL hold its value.
REQ-021 In DONE, the winner's done SHALL be 1 for exactly one cycle, for both reads and writes.
REQ-022 Latency SHALL be: gnt 1 cycle after req sampled, done 2 cycles after req sampled; peak throughput one access per 3 cycles.
REQ-023 A requester whose req stays high through DONE SHALL be eligible in the following IDLE cycle like a new request.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state IDLE, all gnt/done = 0, ram_wr = ram_en = 0, ram_add = 0, ram_d hi-Z, rdata = 0, and round-robin pointer = A.
REQ-025 Reset asserted during ACCESS SHALL abort the access with no done pulse; after release, the request SHALL be re-arbitrated from IDLE.

Configuration
REQ-026 With macro SPR_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the requester not granted last wins, with the pointer updated on each grant.
REQ-027 Without SPR_ARB_RR_EN, A SHALL always win simultaneous requests (fixed priority), and no pointer register SHALL exist.

Structure
REQ-028 Package spr_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and defaults for AW/DW.
REQ-029 The winner-select logic SHALL be the single sub-module spr_arb_pick: inputs req pair, pointer; output one-hot winner.

Verification
REQ-030 Reset, then A write addr 4'h3 data 8'hA5 -> a_gnt on cycle 1, ram_wr=1 with ram_d=8'hA5 and ram_add=3, a_done on cycle 2.
REQ-031 B read addr 4'h3 after REQ-030 -> ram_en=1 and ram_d hi-Z from the arbiter; b_rdata=8'hA5 with b_done; a_rdata unchanged.
REQ-032 A and B request together twice with RR enabled -> grants in order A then B; without the macro -> A then A while A's req is held.
REQ-033 Write addresses 0..15 with data = addr, then read them back -> every rdata equals addr, with no cycle where ram_wr and ram_en are both 1.
REQ-034 rst_n pulsed low during ACCESS of a write -> ram_wr drops asynchronously, no done pulse, and the access is re-granted after release.

Source files
------------

// File: rtl/spr_arb_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter.
package spr_arb_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/spr_arb_pick.sv
// Winner select for requesters A (bit 0) and B (bit 1).
// ptr=1 gives B priority on a tie; ptr=0 gives A priority.
module spr_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    always_comb begin
        if (req == 2'b11) win = ptr ? 2'b10 : 2'b01;
        else              win = req;
    end

endmodule

// File: rtl/spr_arbiter.sv
// Two-port arbiter in front of a single-port RAM with a shared tri-state data bus.
// Define SPR_ARB_RR_EN for round-robin tie-breaking; otherwise A has fixed priority.
import spr_arb_pkg::*;

module spr_arbiter #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          b_req,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_done,
    output logic          b_done,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          ram_wr,
    output logic          ram_en,
    output logic [AW-1:0] ram_add,
    inout  wire  [DW-1:0] ram_d
);

    state_t        state;
    logic          sel_b;
    logic [DW-1:0] wdata_q;
    logic [1:0]    win;
    logic          ptr;

    spr_arb_pick u_pick (
        .req ({b_req, a_req}),
        .ptr (ptr),
        .win (win)
    );

`ifdef SPR_ARB_RR_EN
    // After granting A, B gets the next tie, and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     ptr <= 1'b0;
        else if (state == IDLE && |win) ptr <= win[0];
    end
`else
    assign ptr = 1'b0;
`endif

    // ram_wr is only high during ACCESS of a write, so it doubles as the bus-drive enable.
    assign ram_d = ram_wr ? wdata_q : {DW{1'bz}};

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values; blocking here would make ordering change behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_b   <= 1'b0;
            wdata_q <= '0;
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            a_done  <= 1'b0;
            b_done  <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            ram_wr  <= 1'b0;
            ram_en  <= 1'b0;
            ram_add <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|win) begin
                        state   <= ACCESS;
                        sel_b   <= win[1];
                        wdata_q <= win[1] ? b_wdata : a_wdata;
                        ram_add <= win[1] ? b_addr : a_addr;
                        ram_wr  <= win[1] ? b_we : a_we;
                        ram_en  <= win[1] ? !b_we : !a_we;
                        a_gnt   <= win[0];
                        b_gnt   <= win[1];
                    end
                end
                ACCESS: begin
                    state  <= DONE;
                    a_gnt  <= 1'b0;
                    b_gnt  <= 1'b0;
                    ram_wr <= 1'b0;
                    ram_en <= 1'b0;
                    if (ram_en) begin
                        if (sel_b) b_rdata <= ram_d;
                        else       a_rdata <= ram_d;
                    end
                    a_done <= !sel_b;
                    b_done <= sel_b;
                end
                DONE: begin
                    state  <= IDLE;
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spr_arbiter.sv
// Self-checking bench for spr_arbiter: directed scenarios plus random traffic
// against a transaction-level model (expected memory, rdata and tie-break turn).
module tb_spr_arbiter;

`ifdef SPR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [3:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_gnt, b_gnt, a_done, b_done, ram_wr, ram_en;
    logic [7:0] a_rdata, b_rdata;
    logic [3:0] ram_add;
    wire  [7:0] ram_d;

    logic [7:0] tb_mem [16];
    logic [7:0] exp_mem [16];
    logic [7:0] exp_ar = '0, exp_br = '0;
    bit         b_turn = 1'b0;
    int         checks = 0, errors = 0, overlap = 0;

    spr_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .b_req   (b_req),
        .a_we    (a_we),
        .b_we    (b_we),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .a_wdata (a_wdata),
        .b_wdata (b_wdata),
        .a_gnt   (a_gnt),
        .b_gnt   (b_gnt),
        .a_done  (a_done),
        .b_done  (b_done),
        .a_rdata (a_rdata),
        .b_rdata (b_rdata),
        .ram_wr  (ram_wr),
        .ram_en  (ram_en),
        .ram_add (ram_add),
        .ram_d   (ram_d)
    );

    always #5 clk = ~clk;

    // External single-port RAM: combinational read onto the bus, write on the edge.
    assign ram_d = ram_en ? tb_mem[ram_add] : 8'bz;
    always @(posedge clk) if (ram_wr) tb_mem[ram_add] <= ram_d;

    always @(negedge clk) if (ram_wr && ram_en) overlap++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full arbitration round starting in IDLE with the current req/command inputs.
    task automatic txn(input bit hold);
        bit         wb;
        logic       we;
        logic [3:0] ad;
        logic [7:0] wd;
        if (a_req && b_req) wb = RR ? b_turn : 1'b0;
        else                wb = b_req;
        we = wb ? b_we : a_we;
        ad = wb ? b_addr : a_addr;
        wd = wb ? b_wdata : a_wdata;
        step();
        check("a_gnt", a_gnt, !wb);
        check("b_gnt", b_gnt, wb);
        check("ram_wr", ram_wr, we);
        check("ram_en", ram_en, !we);
        check("ram_add", ram_add, ad);
        check("ram_d", ram_d, we ? wd : exp_mem[ad]);
        if (we)      exp_mem[ad] = wd;
        else if (wb) exp_br = exp_mem[ad];
        else         exp_ar = exp_mem[ad];
        b_turn = !wb;
        if (!hold) begin
            // Withdraw the winner and scramble its command; the latched copy must be used.
            if (wb) begin
                b_req = 1'b0; b_we = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
            end else begin
                a_req = 1'b0; a_we = 1'($urandom); a_addr = 4'($urandom); a_wdata = 8'($urandom);
            end
        end
        step();
        check("a_done", a_done, !wb);
        check("b_done", b_done, wb);
        check("a_rdata", a_rdata, exp_ar);
        check("b_rdata", b_rdata, exp_br);
        check("gnt_clear", {a_gnt, b_gnt, ram_wr, ram_en}, 4'b0);
        step();
        check("done_clear", {a_done, b_done}, 2'b0);
    endtask

    initial begin
        repeat (3) step();
        check("rst_gnt", {a_gnt, b_gnt, a_done, b_done}, 4'b0);
        check("rst_ram", {ram_wr, ram_en, ram_add}, 6'b0);
        check("rst_rdata", {a_rdata, b_rdata}, 16'b0);
        rst_n = 1'b1;

        // A writes A5 to address 3, then B reads it back.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'h3; a_wdata = 8'hA5;
        txn(1'b0);
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'h3;
        txn(1'b0);

        // Simultaneous requests held across two rounds, then drain what is left.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'h7; a_wdata = 8'h11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'h8; b_wdata = 8'h22;
        txn(1'b1);
        txn(1'b1);
        a_req = 1'b0;
        txn(1'b0);

        // Fill every address with its own value and read all of them back.
        for (int i = 0; i < 16; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 4'(i); a_wdata = 8'(i);
            txn(1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            b_req = 1'b1; b_we = 1'b0; b_addr = 4'(i);
            txn(1'b0);
        end

        // Reset in the middle of a write access.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'h5; a_wdata = 8'h3C;
        step();
        check("abort_wr_before", ram_wr, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ram", {ram_wr, ram_en, ram_add}, 6'b0);
        check("abort_gnt", {a_gnt, b_gnt}, 2'b0);
        check("abort_rdata", {a_rdata, b_rdata}, 16'b0);
        exp_ar = '0; exp_br = '0; b_turn = 1'b0;
        step();
        check("abort_no_done", {a_done, b_done}, 2'b0);
        rst_n = 1'b1;
        txn(1'b0);

        // Random traffic; a pending loser keeps its request and command.
        for (int n = 0; n < 40; n++) begin
            if (!a_req && $urandom_range(1) == 1) begin
                a_req = 1'b1; a_we = 1'($urandom); a_addr = 4'($urandom); a_wdata = 8'($urandom);
            end
            if (!b_req && $urandom_range(1) == 1) begin
                b_req = 1'b1; b_we = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
            end
            if (!a_req && !b_req) begin
                b_req = 1'b1; b_we = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
            end
            txn(1'b0);
        end

        check("no_wr_en_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
